// File: rtl/uart_hex_key_rx_pkg.sv
// Shared constants, receiver state type and the ASCII hex decoder
// for the hex-key UART receive path.
package uart_hex_key_rx_pkg;

  localparam int DEF_BAUD_DIV    = 104;  // 12 MHz / 115200
  localparam int DEF_NUM_NIBBLES = 64;
  localparam int KEY_W           = 4 * DEF_NUM_NIBBLES;

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_A  = 8'h41;
  localparam logic [7:0] CHAR_a  = 8'h61;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Returns {is_hex, nibble}; nibble is 0 when the character is not a hex digit.
  function automatic logic [4:0] hex_to_nibble(input logic [7:0] ch);
    logic [7:0] diff;
    logic [4:0] result;
    result = 5'b0;
    diff   = 8'h00;
    if (ch >= CHAR_0 && ch <= CHAR_0 + 8'd9) begin
      diff   = ch - CHAR_0;
      result = {1'b1, diff[3:0]};
    end else if (ch >= CHAR_A && ch <= CHAR_A + 8'd5) begin
      diff   = ch - CHAR_A + 8'd10;
      result = {1'b1, diff[3:0]};
    end else if (ch >= CHAR_a && ch <= CHAR_a + 8'd5) begin
      diff   = ch - CHAR_a + 8'd10;
      result = {1'b1, diff[3:0]};
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_hex_key_rx_if.sv
// Key hand-off bundle: parsed value with valid/ready handshake.
interface uart_hex_key_rx_if
  import uart_hex_key_rx_pkg::*;
#(
  parameter int NUM_NIBBLES = DEF_NUM_NIBBLES
);

  logic [4*NUM_NIBBLES-1:0] key_out;
  logic                     key_valid;
  logic                     key_ready;

  // Producer side (the receiver)
  modport master (
    output key_out,
    output key_valid,
    input  key_ready
  );

  // Consumer side (ECC control logic)
  modport slave (
    input  key_out,
    input  key_valid,
    output key_ready
  );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer followed by a start/data/stop
// sampling FSM. Sample points fall mid-bit because the start search and
// all later samples read the same synchronized signal.
module uart_rx_byte
  import uart_hex_key_rx_pkg::*;
#(
  parameter int BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] byte_data,
  output logic       byte_strobe,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);

  logic [1:0]       sync_q;
  logic             rx_s;
  rx_state_e        state_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             byte_strobe_q;
  logic             frame_err_q;

  assign rx_s        = sync_q[1];
  assign byte_data   = shift_q;
  assign byte_strobe = byte_strobe_q;
  assign frame_err   = frame_err_q;

  // Bring the asynchronous pin into the clock domain; idle-high reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], uart_rx};
  end

  // Bit-timing FSM with registered one-cycle strobe and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RX_IDLE;
      baud_cnt_q    <= '0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      byte_strobe_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      byte_strobe_q <= 1'b0;
      frame_err_q   <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          baud_cnt_q <= '0;
          if (!rx_s) state_q <= RX_START;
        end
        RX_START: begin
          if (baud_cnt_q == HALF_LAST) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            // A start bit that has vanished by mid-bit is treated as noise.
            state_q    <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_cnt_q == BIT_LAST) begin
            baud_cnt_q <= '0;
            shift_q    <= {rx_s, shift_q[7:1]};
            if (bit_idx_q == 3'd7) state_q <= RX_STOP;
            else                   bit_idx_q <= bit_idx_q + 1'b1;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (baud_cnt_q == BIT_LAST) begin
            baud_cnt_q <= '0;
            state_q    <= RX_IDLE;
            if (rx_s) byte_strobe_q <= 1'b1;
            else      frame_err_q   <= 1'b1;
          end else begin
            baud_cnt_q <= baud_cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_hex_key_rx.sv
// Receives a line of hex digits over UART, assembles the key value and
// hands it to the consumer with a valid/ready handshake.
module uart_hex_key_rx
  import uart_hex_key_rx_pkg::*;
#(
  parameter int BAUD_DIV    = DEF_BAUD_DIV,
  parameter int NUM_NIBBLES = DEF_NUM_NIBBLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  uart_hex_key_rx_if.master key_if,
  output logic              line_err,
  output logic              frame_err
);

  localparam int W     = 4 * NUM_NIBBLES;
  localparam int CNT_W = $clog2(NUM_NIBBLES + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_NIBBLES);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(NUM_NIBBLES + 1);

  logic [7:0]       byte_data;
  logic             byte_strobe;
  logic             rx_frame_err;
  logic [4:0]       hex_dec;
  logic             accept;
  logic             line_good;

  logic [W-1:0]     acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bad_q;
  logic [W-1:0]     key_out_q;
  logic             key_valid_q;
  logic             line_err_q;

  uart_rx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx     (uart_rx),
    .byte_data   (byte_data),
    .byte_strobe (byte_strobe),
    .frame_err   (rx_frame_err)
  );

  assign hex_dec          = hex_to_nibble(byte_data);
  assign accept           = key_valid_q && key_if.key_ready;
  assign line_good        = (cnt_q == CNT_FULL) && !bad_q;
  assign key_if.key_out   = key_out_q;
  assign key_if.key_valid = key_valid_q;
  assign line_err         = line_err_q;
  assign frame_err        = rx_frame_err;

  // Line parser and output handshake; an accept in the same cycle as a
  // good line end frees the slot so the new line loads without overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      bad_q       <= 1'b0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      line_err_q  <= 1'b0;
    end else begin
      line_err_q <= 1'b0;
      if (accept) key_valid_q <= 1'b0;

      if (byte_strobe) begin
        if (hex_dec[4]) begin
          acc_q <= {acc_q[W-5:0], hex_dec[3:0]};
          if (cnt_q == CNT_FULL) bad_q <= 1'b1;
          if (cnt_q != CNT_OVER) cnt_q <= cnt_q + 1'b1;
        end else if (byte_data == CHAR_LF) begin
          cnt_q <= '0;
          bad_q <= 1'b0;
          if (line_good) begin
            if (!key_valid_q || accept) begin
              key_out_q   <= acc_q;
              key_valid_q <= 1'b1;
            end else begin
              line_err_q <= 1'b1;
            end
          end else if (cnt_q != '0 || bad_q) begin
            // Anything but an empty clean line is reported.
            line_err_q <= 1'b1;
          end
        end else if (byte_data != CHAR_CR) begin
          bad_q <= 1'b1;
        end
      end

      // A lost byte poisons the rest of the current line.
      if (rx_frame_err) bad_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_hex_key_rx.sv
// Directed bench for uart_hex_key_rx: serializes hex lines onto uart_rx
// at a shortened bit period and checks key, handshake and error pulses.
module tb_uart_hex_key_rx;

  localparam int B = 6;  // clock cycles per bit in this bench

  logic clk;
  logic rst_n;
  logic uart_rx;
  logic line_err;
  logic frame_err;

  uart_hex_key_rx_if key_if ();

  uart_hex_key_rx #(
    .BAUD_DIV (B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .key_if    (key_if),
    .line_err  (line_err),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int line_err_seen = 0;
  int frame_err_seen = 0;
  bit strobe_seen;

  // Count every cycle the error pulses are high.
  always @(negedge clk) begin
    line_err_seen  <= line_err_seen + int'(line_err);
    frame_err_seen <= frame_err_seen + int'(frame_err);
  end

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic send_byte(input logic [7:0] ch, input bit good_stop);
    uart_rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = ch[i];
      repeat (B) @(negedge clk);
    end
    uart_rx = good_stop;
    repeat (B) @(negedge clk);
    if (!good_stop) begin
      uart_rx = 1'b1;
      repeat (2 * B) @(negedge clk);
    end
  endtask

  function automatic logic [7:0] nib_char(input logic [3:0] n, input bit lower);
    logic [7:0] c;
    if (n < 4'd10)  c = 8'h30 + {4'h0, n};
    else if (lower) c = 8'h61 + {4'h0, n} - 8'd10;
    else            c = 8'h41 + {4'h0, n} - 8'd10;
    return c;
  endfunction

  // 64 digits of v, MSN first; the digit at bad_idx gets a low stop bit.
  task automatic send_hex(input logic [255:0] v, input bit lower, input int bad_idx);
    for (int i = 0; i < 64; i++)
      send_byte(nib_char(v[4*(63-i) +: 4], lower), (i != bad_idx));
  endtask

  task automatic send_rep(input logic [7:0] ch, input int n);
    for (int i = 0; i < n; i++) send_byte(ch, 1'b1);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic accept_key();
    key_if.key_ready = 1'b1;
    @(negedge clk);
    key_if.key_ready = 1'b0;
  endtask

  logic [255:0] ones;
  logic [255:0] v1, v2, v3, v4, v5;
  int le0, fe0;

  initial begin
    ones = '1;
    v1 = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
    v2 = 256'hDEADBEEF_CAFEF00D_01234567_89ABCDEF_13579BDF_2468ACE0_FFFFFFFF_00000001;
    v3 = {32{8'hA5}};
    v4 = 256'h1;
    v5 = {8{32'h9E3779B9}};

    rst_n = 1'b0;
    uart_rx = 1'b1;
    key_if.key_ready = 1'b0;
    repeat (4) @(negedge clk);
    check_val("rst_key_out", key_if.key_out, 256'h0);
    check_val("rst_key_valid", {255'h0, key_if.key_valid}, 256'h0);
    check_val("rst_line_err", {255'h0, line_err}, 256'h0);
    check_val("rst_frame_err", {255'h0, frame_err}, 256'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 2^71: single '8' at digit 46 from the left.
    le0 = line_err_seen;
    for (int i = 0; i < 64; i++) send_byte((i == 46) ? 8'h38 : 8'h30, 1'b1);
    send_byte(8'h0A, 1'b1);
    settle();
    check_val("pow71_valid", {255'h0, key_if.key_valid}, 256'h1);
    check_val("pow71_key", key_if.key_out, 256'h1 << 71);
    accept_key();
    check_val("pow71_accept_valid", {255'h0, key_if.key_valid}, 256'h0);
    check_val("pow71_key_held", key_if.key_out, 256'h1 << 71);

    // Lowercase digits with CR before LF.
    send_rep(8'h66, 64);
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0A, 1'b1);
    settle();
    check_val("ff_crlf_valid", {255'h0, key_if.key_valid}, 256'h1);
    check_val("ff_crlf_key", key_if.key_out, ones);
    check_val("ff_crlf_line_err", 256'(line_err_seen - le0), 256'h0);
    accept_key();

    // Short, long and non-hex lines, then an empty line.
    le0 = line_err_seen;
    send_rep(8'h35, 63); send_byte(8'h0A, 1'b1);
    send_rep(8'h37, 65); send_byte(8'h0A, 1'b1);
    send_byte(8'h31, 1'b1); send_byte(8'h32, 1'b1);
    send_byte(8'h47, 1'b1); send_byte(8'h34, 1'b1);
    send_rep(8'h30, 60); send_byte(8'h0A, 1'b1);
    settle();
    check_val("bad_lines_line_err", 256'(line_err_seen - le0), 256'h3);
    check_val("bad_lines_valid", {255'h0, key_if.key_valid}, 256'h0);
    check_val("bad_lines_key_kept", key_if.key_out, ones);
    send_byte(8'h0A, 1'b1);
    settle();
    check_val("empty_line_no_err", 256'(line_err_seen - le0), 256'h3);

    // Bad stop bit on the tenth digit poisons the line; next line is clean.
    le0 = line_err_seen;
    fe0 = frame_err_seen;
    send_hex(v2, 1'b0, 9);
    send_byte(8'h0A, 1'b1);
    settle();
    check_val("frame_err_pulse", 256'(frame_err_seen - fe0), 256'h1);
    check_val("frame_line_err", 256'(line_err_seen - le0), 256'h1);
    check_val("frame_valid", {255'h0, key_if.key_valid}, 256'h0);
    send_hex(v1, 1'b0, -1);
    send_byte(8'h0A, 1'b1);
    settle();
    check_val("after_frame_valid", {255'h0, key_if.key_valid}, 256'h1);
    check_val("after_frame_key", key_if.key_out, v1);

    // Overrun: consumer stalled, second line is dropped.
    le0 = line_err_seen;
    send_hex(v2, 1'b1, -1);
    send_byte(8'h0A, 1'b1);
    settle();
    check_val("overrun_key_kept", key_if.key_out, v1);
    check_val("overrun_valid", {255'h0, key_if.key_valid}, 256'h1);
    check_val("overrun_line_err", 256'(line_err_seen - le0), 256'h1);
    accept_key();

    // Accept in the same cycle as the next good line end.
    le0 = line_err_seen;
    send_hex(v3, 1'b0, -1);
    send_byte(8'h0A, 1'b1);
    settle();
    check_val("v3_key", key_if.key_out, v3);
    send_hex(v4, 1'b1, -1);
    strobe_seen = 1'b0;
    fork
      send_byte(8'h0A, 1'b1);
      begin
        for (int k = 0; k < 12 * B && !strobe_seen; k++) begin
          @(negedge clk);
          if (dut.byte_strobe) begin
            strobe_seen = 1'b1;
            key_if.key_ready = 1'b1;
            @(negedge clk);
            key_if.key_ready = 1'b0;
          end
        end
      end
    join
    settle();
    check_val("same_cycle_strobe_found", {255'h0, strobe_seen}, 256'h1);
    check_val("same_cycle_key", key_if.key_out, v4);
    check_val("same_cycle_valid", {255'h0, key_if.key_valid}, 256'h1);
    check_val("same_cycle_no_err", 256'(line_err_seen - le0), 256'h0);

    // Reset in the middle of byte 30 while a key is pending.
    send_rep(8'h33, 29);
    uart_rx = 1'b0;
    repeat (B) @(negedge clk);
    uart_rx = 1'b1; repeat (B) @(negedge clk);
    uart_rx = 1'b0; repeat (B) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("midrst_key_out", key_if.key_out, 256'h0);
    check_val("midrst_valid", {255'h0, key_if.key_valid}, 256'h0);
    check_val("midrst_line_err", {255'h0, line_err}, 256'h0);
    check_val("midrst_frame_err", {255'h0, frame_err}, 256'h0);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * B) @(negedge clk);

    // One-cycle glitch must not produce a byte that would spoil the line.
    le0 = line_err_seen;
    fe0 = frame_err_seen;
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (4 * B) @(negedge clk);
    send_hex(v5, 1'b0, -1);
    send_byte(8'h0A, 1'b1);
    settle();
    check_val("post_rst_valid", {255'h0, key_if.key_valid}, 256'h1);
    check_val("post_rst_key", key_if.key_out, v5);
    check_val("glitch_no_line_err", 256'(line_err_seen - le0), 256'h0);
    check_val("glitch_no_frame_err", 256'(frame_err_seen - fe0), 256'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
